// File: rtl/lsu_dccm_arb.sv
// DCCM port arbiter: DC1 loads, store-buffer drain and a 2-deep DMA queue.
// Define RV_DCCM_ARB_STARVE_EN to enable store-buffer starvation forcing.
module lsu_dccm_arb #(
  parameter int AW         = 16,
  parameter int FDW        = 39,
  parameter int BANK_LSB   = 2,
  parameter int BANK_BITS  = 2,
  parameter int STARVE_MAX = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ld_req,
  input  logic [AW-1:0]  ld_addr_lo,
  input  logic [AW-1:0]  ld_addr_hi,
  output logic           ld_stall,
  input  logic           sb_req,
  input  logic [AW-1:0]  sb_addr,
  input  logic [FDW-1:0] sb_wdata,
  output logic           sb_gnt,
  input  logic           dma_valid,
  input  logic           dma_write,
  input  logic [AW-1:0]  dma_addr,
  input  logic [FDW-1:0] dma_wdata,
  output logic           dma_ready,
  output logic           dma_rsp_valid,
  output logic [FDW-1:0] dma_rsp_data,
  output logic           dccm_wren,
  output logic           dccm_rden,
  output logic [AW-1:0]  dccm_wr_addr,
  output logic [AW-1:0]  dccm_rd_addr_lo,
  output logic [AW-1:0]  dccm_rd_addr_hi,
  output logic [FDW-1:0] dccm_wr_data,
  input  logic [FDW-1:0] dccm_rd_data_lo
);

  typedef struct packed {
    logic           wr;
    logic [AW-1:0]  addr;
    logic [FDW-1:0] data;
  } dma_ent_t;

  function automatic logic [BANK_BITS-1:0] bank(input logic [AW-1:0] a);
    return a[BANK_LSB +: BANK_BITS];
  endfunction

  dma_ent_t       fifo_q [2];
  dma_ent_t       head;
  logic           wp_q, wp_d;
  logic           rp_q, rp_d;
  logic [1:0]     cnt_q, cnt_d;
  logic           rr_q, rr_d;
  logic           rsp_p1_q;
  logic           rsp_v_q;
  logic [FDW-1:0] rsp_data_q;

  logic           head_vld;
  logic           rd_dma, rd_any;
  logic           dma_wc, pick_sb, pick_dma;
  logic [BANK_BITS-1:0] rb_lo, rb_hi, wr_bank;
  logic           conflict;
  logic           wr_go, rd_go;
  logic           sb_go, dma_wr_go, dma_rd_go;
  logic           push, pop;
  logic           starve_force;

  assign head     = fifo_q[rp_q];
  assign head_vld = (cnt_q != 2'd0);

  always_comb begin
    rd_dma   = ~ld_req & head_vld & ~head.wr;
    rd_any   = ld_req | rd_dma;
    rb_lo    = ld_req ? bank(ld_addr_lo) : bank(head.addr);
    rb_hi    = ld_req ? bank(ld_addr_hi) : bank(head.addr);
    dma_wc   = head_vld & head.wr;
    // rr_q high means the DMA side has priority on the next contention
    pick_sb  = starve_force | (sb_req & ~(dma_wc & rr_q));
    pick_dma = ~pick_sb & dma_wc;
    wr_bank  = pick_sb ? bank(sb_addr) : bank(head.addr);
    conflict = rd_any & (pick_sb | pick_dma) &
               ((wr_bank == rb_lo) | (wr_bank == rb_hi));
    wr_go    = (pick_sb | pick_dma) & (~conflict | starve_force);
    rd_go    = rd_any & ~(conflict & starve_force);
    sb_go    = ~rst & pick_sb & wr_go;
    dma_wr_go = ~rst & pick_dma & wr_go;
    dma_rd_go = ~rst & rd_dma & rd_go;
  end

  assign sb_gnt          = sb_go;
  assign dccm_wren       = ~rst & wr_go;
  assign dccm_rden       = ~rst & rd_go;
  assign dccm_wr_addr    = pick_sb ? sb_addr : head.addr;
  assign dccm_wr_data    = pick_sb ? sb_wdata : head.data;
  assign dccm_rd_addr_lo = ld_req ? ld_addr_lo : head.addr;
  assign dccm_rd_addr_hi = ld_req ? ld_addr_hi : head.addr;

  assign dma_ready = ~rst & (cnt_q != 2'd2);
  assign push      = dma_valid & dma_ready;
  assign pop       = dma_rd_go | dma_wr_go;

  always_comb begin
    wp_d  = push ? ~wp_q : wp_q;
    rp_d  = pop ? ~rp_q : rp_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    rr_d  = rr_q;
    if (sb_req & dma_wc & wr_go)
      rr_d = pick_sb;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= 2'd0;
      rr_q     <= 1'b0;
      rsp_p1_q <= 1'b0;
      rsp_v_q  <= 1'b0;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      rsp_p1_q <= dma_rd_go;
      rsp_v_q  <= rsp_p1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_q[wp_q] <= '{wr: dma_write, addr: dma_addr, data: dma_wdata};
    if (rsp_p1_q)
      rsp_data_q <= dccm_rd_data_lo;
  end

  assign dma_rsp_valid = rsp_v_q;
  assign dma_rsp_data  = rsp_data_q;

`ifdef RV_DCCM_ARB_STARVE_EN
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [SW-1:0] starve_q, starve_d;

  assign starve_force = sb_req & (starve_q == SW'(STARVE_MAX));
  assign ld_stall     = ~rst & starve_force & conflict & ld_req;

  always_comb begin
    starve_d = starve_q;
    if (sb_go)
      starve_d = '0;
    else if (sb_req & (starve_q != SW'(STARVE_MAX)))
      starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      starve_q <= '0;
    else
      starve_q <= starve_d;
  end
`else
  assign starve_force = 1'b0;
  assign ld_stall     = 1'b0;
`endif

endmodule
